if_fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the combinational byte-addressed IMEM.

---
 rtl/if_pkg.sv | 18 +
 rtl/fetch_buf.sv | 62 ++++++
 rtl/if_fetch_unit.sv | 84 ++++++++
 tb/tb_if_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch unit.
// Holds the NOP constant, the buffered entry layout and the fetch states.
package if_pkg;

  localparam logic [31:0] IF_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } if_entry_t;

  typedef enum logic {
    IF_RUN,
    IF_STOP
  } if_state_e;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO with flush and simultaneous push/pop.
// Ports: clk, rst, i_flush, i_push, i_pop, i_data -> o_valid, o_full, o_data.
module fetch_buf
  import if_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_flush,
  input  logic      i_push,
  input  logic      i_pop,
  input  if_entry_t i_data,
  output logic      o_valid,
  output logic      o_full,
  output if_entry_t o_data
);

  if_entry_t   r_e0;
  if_entry_t   r_e1;
  logic [1:0]  r_cnt;
  logic        w_pop;
  logic        w_push;

  // r_e0 is always the head; r_e1 is the second slot.
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_e0 <= i_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_data  = o_valid ? r_e0 : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the fetch PC, checks it, and queues fetched words.
// Ports: IMEM addr/data, EX redirect, valid/ready decode handshake.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 1024,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_SIZE - 4);

  if (BUF_DEPTH != 2) begin : g_depth_chk
    $error("if_fetch_unit: only BUF_DEPTH=2 is supported");
  end

  logic [31:0] r_fpc;
  if_state_e   r_state;

  logic        w_bad;
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_valid;
  if_entry_t   w_in;
  if_entry_t   w_head;

  // Fault check runs before any wrap can happen.
  assign w_bad = (r_fpc[1:0] != 2'b00) || (r_fpc > LAST_PC);

  assign w_pop  = w_valid && if_ready;
  assign w_push = (r_state == IF_RUN) && !redirect_valid
               && (!w_full || w_pop);

  always_comb begin
    w_in.pc    = r_fpc;
    w_in.instr = w_bad ? IF_NOP : imem_instr;
    w_in.fault = w_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc   <= RESET_PC;
      r_state <= IF_RUN;
    end else if (redirect_valid) begin
      r_fpc   <= redirect_pc;
      r_state <= IF_RUN;
    end else if (w_push) begin
      if (w_bad) r_state <= IF_STOP;
      else       r_fpc   <= r_fpc + 32'd4;
    end
  end

  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_data  (w_head)
  );

  assign imem_pc  = r_fpc;
  assign if_valid = w_valid;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;
  assign if_fault = w_head.fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural byte-addressed IMEM.
// A second instance with IMEM_SIZE=64 exercises the end-of-range fault.
module tb_if_fetch_unit;

  localparam logic [31:0] PROG [16] = '{
    32'h0050_0113, 32'h0040_0093, 32'h0020_81b3, 32'h4020_8233,
    32'h0020_f2b3, 32'h0020_e333, 32'h0020_c3b3, 32'h0020_9433,
    32'h4010_e433, 32'h0011_2493, 32'h0ff0_f513, 32'h1234_55b7,
    32'h0000_1617, 32'h0030_d693, 32'h0021_a713, 32'hfff0_0793
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        ready64;

  logic [31:0] imem_pc, imem_instr, if_pc, if_instr;
  logic        if_valid, if_fault;
  logic [31:0] imem_pc64, imem_instr64, if_pc64, if_instr64;
  logic        if_valid64, if_fault64;

  logic [31:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] x;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      x = a + 32'(b);
      if (x < 32'd1024)
        w[8*b +: 8] = mem[x[9:2]][8*x[1:0] +: 8];
    end
    return w;
  endfunction

  always_comb begin
    imem_instr = '0;
    imem_instr = imem_rd(imem_pc);
  end

  always_comb begin
    imem_instr64 = '0;
    imem_instr64 = imem_rd(imem_pc64);
  end

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  if_fetch_unit #(.IMEM_SIZE(64)) dut64 (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc64),
    .imem_instr     (imem_instr64),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (if_valid64),
    .if_ready       (ready64),
    .if_pc          (if_pc64),
    .if_instr       (if_instr64),
    .if_fault       (if_fault64)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 16) ? PROG[i] : (32'h13 | (32'(i) << 20));

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    ready64 = 1'b1;
    step();
    step();

    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_fault", 32'(if_fault), 32'd0);
    chk("rst_imem_pc", imem_pc, 32'h0);

    // 1. sequential stream, both instances
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k <= 16) begin
        chk("seq_valid", 32'(if_valid), 32'd1);
        chk("seq_pc", if_pc, 32'(4 * (k - 1)));
        chk("seq_instr", if_instr, PROG[k-1]);
        chk("s64_pc", if_pc64, 32'(4 * (k - 1)));
        chk("s64_fault", 32'(if_fault64), 32'd0);
      end else if (k == 17) begin
        chk("s64_fvalid", 32'(if_valid64), 32'd1);
        chk("s64_fpc", if_pc64, 32'h40);
        chk("s64_finstr", if_instr64, 32'h13);
        chk("s64_ffault", 32'(if_fault64), 32'd1);
      end else begin
        chk("s64_stop", 32'(if_valid64), 32'd0);
        chk("s64_hold", imem_pc64, 32'h40);
      end
    end

    // 2. backpressure
    rst = 1'b1;
    if_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_pc", if_pc, 32'h0);
      if (k >= 2) chk("bp_imem", imem_pc, 32'h8);
    end
    if_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rel_pc", if_pc, 32'(4 * k));
      chk("rel_instr", if_instr, PROG[k]);
    end

    // 3. redirect with a full buffer
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(if_valid), 32'd0);
    chk("rd_pc0", if_pc, 32'h0);
    chk("rd_imem", imem_pc, 32'h20);
    step();
    chk("rd_valid2", 32'(if_valid), 32'd1);
    chk("rd_pc", if_pc, 32'h20);
    chk("rd_instr", if_instr, 32'h4010_e433);

    // 4. misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_v0", 32'(if_valid), 32'd0);
    step();
    chk("mis_valid", 32'(if_valid), 32'd1);
    chk("mis_pc", if_pc, 32'h22);
    chk("mis_instr", if_instr, 32'h13);
    chk("mis_fault", 32'(if_fault), 32'd1);
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mis_stop", 32'(if_valid), 32'd0);
      chk("mis_sfault", 32'(if_fault), 32'd0);
      chk("mis_hold", imem_pc, 32'h22);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("res_v0", 32'(if_valid), 32'd0);
    step();
    chk("res_pc", if_pc, 32'h0);
    chk("res_instr", if_instr, PROG[0]);
    chk("res_fault", 32'(if_fault), 32'd0);

    // 6. reset beats redirect
    if_ready = 1'b0;
    step();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    chk("rr_valid", 32'(if_valid), 32'd0);
    chk("rr_imem", imem_pc, 32'h0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk("rr_valid2", 32'(if_valid), 32'd1);
    chk("rr_pc", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
